// File: rtl/uart_pkt_parser_if.sv
// Byte-stream bundle between the UART receiver, the packet parser and the payload sink.
// slave = parser side, master = environment side.
interface uart_pkt_parser_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_perr;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;

  modport slave (
    input  s_tdata, s_tvalid, s_perr, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, pkt_ok, pkt_err, err_code
  );
  modport master (
    output s_tdata, s_tvalid, s_perr, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, pkt_ok, pkt_err, err_code
  );
endinterface

// File: rtl/uart_pkt_parser.sv
// Header-hunting packet parser: 55 AA len payload csum, releases only verified payloads.
// Optional inter-byte timeout enabled by defining PKT_TIMEOUT_EN.
module uart_pkt_parser #(
  parameter logic [7:0] HDR0           = 8'h55,
  parameter logic [7:0] HDR1           = 8'hAA,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  uart_pkt_parser_if.slave bus
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]    MAX_B = 8'(MAX_LEN);
  localparam logic [IW-1:0] ONE   = IW'(1);

  localparam logic [2:0] S_HUNT0   = 3'd0;
  localparam logic [2:0] S_HUNT1   = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CSUM    = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  logic [2:0]    st_q, st_d;
  logic [IW-1:0] len_q, len_d, idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic          ok_q, ok_d, err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          wr_en, acc, s_rdy, m_vld, m_last;
  logic [7:0]    b;
  logic [7:0]    buf_q [MAX_LEN];

  // Reset is active-high on rst_n; the parser never accepts while held in reset.
  assign s_rdy  = ~rst_n & (st_q != S_OUT);
  assign acc    = bus.s_tvalid & s_rdy;
  assign b      = bus.s_tdata;
  assign m_vld  = (st_q == S_OUT);
  assign m_last = m_vld && (idx_q == len_q - ONE);

  assign bus.s_tready = s_rdy;
  assign bus.m_tvalid = m_vld;
  assign bus.m_tlast  = m_last;
  assign bus.m_tdata  = m_vld ? buf_q[idx_q[AW-1:0]] : 8'h00;
  assign bus.pkt_ok   = ok_q;
  assign bus.pkt_err  = err_q;
  assign bus.err_code = code_q;

  logic tmo_hit;
`ifdef PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_act;

  assign tmo_act = (st_q == S_HUNT1) || (st_q == S_LEN) || (st_q == S_PAYLOAD) || (st_q == S_CSUM);
  assign tmo_hit = tmo_act && !acc && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Restart the idle count on any accepted byte or state change.
  always_comb tmo_d = (!tmo_act || acc || (st_d != st_q)) ? '0 : tmo_q + TW'(1);

  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) tmo_q <= '0;
    else       tmo_q <= tmo_d;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    sum_d  = sum_q;
    idx_d  = idx_q;
    ok_d   = 1'b0;
    err_d  = 1'b0;
    code_d = code_q;
    wr_en  = 1'b0;
    case (st_q)
      S_HUNT0:
        if (acc && !bus.s_perr && b == HDR0) st_d = S_HUNT1;
      S_HUNT1:
        if (acc) begin
          if (bus.s_perr)    st_d = S_HUNT0;
          else if (b == HDR1) st_d = S_LEN;
          else if (b == HDR0) st_d = S_HUNT1;
          else                st_d = S_HUNT0;
        end
      S_LEN:
        if (acc) begin
          if (bus.s_perr) begin
            st_d = S_HUNT0; err_d = 1'b1; code_d = 2'b11;
          end else if (b == 8'h00 || b > MAX_B) begin
            st_d = S_HUNT0; err_d = 1'b1; code_d = 2'b01;
          end else begin
            len_d = b[IW-1:0]; sum_d = b; idx_d = '0; st_d = S_PAYLOAD;
          end
        end
      S_PAYLOAD:
        if (acc) begin
          if (bus.s_perr) begin
            st_d = S_HUNT0; err_d = 1'b1; code_d = 2'b11;
          end else begin
            wr_en = 1'b1;
            sum_d = sum_q + b;
            idx_d = idx_q + ONE;
            if (idx_d == len_q) st_d = S_CSUM;
          end
        end
      S_CSUM:
        if (acc) begin
          if (bus.s_perr) begin
            st_d = S_HUNT0; err_d = 1'b1; code_d = 2'b11;
          end else if (b == sum_q) begin
            st_d = S_OUT; ok_d = 1'b1; idx_d = '0;
          end else begin
            st_d = S_HUNT0; err_d = 1'b1; code_d = 2'b10;
          end
        end
      S_OUT:
        if (bus.m_tready) begin
          if (m_last) begin
            st_d = S_HUNT0; idx_d = '0;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      default: st_d = S_HUNT0;
    endcase
    // Timeout out of HUNT1 is silent; out of a frame it reports code 00.
    if (tmo_hit) begin
      st_d = S_HUNT0;
      if (st_q != S_HUNT1) begin
        err_d = 1'b1; code_d = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      st_q   <= S_HUNT0;
      len_q  <= '0;
      idx_q  <= '0;
      sum_q  <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      code_q <= 2'b00;
    end else begin
      st_q   <= st_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      sum_q  <= sum_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  always_ff @(posedge clk)
    if (wr_en) buf_q[idx_q[AW-1:0]] <= b;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed scenarios plus randomized frame streams scored against a byte-level parser model.
module tb_uart_pkt_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic rnd_rdy = 1'b0;
  logic rnd_bit = 1'b1;
  logic rdy_dir = 1'b0;
  logic mon_en = 1'b0;

  logic [7:0] sd[$];
  bit         sp[$];
  int exp_d[$], exp_ev[$], obs_d[$], obs_ev[$];
  int both_viol, stab_viol, rdy_viol;
  logic prev_stall;
  logic [8:0] prev_dl;

  uart_pkt_parser_if bus ();

  uart_pkt_parser dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  assign bus.m_tready = rnd_rdy ? rnd_bit : rdy_dir;

  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.m_tvalid && bus.m_tready) obs_d.push_back(int'({bus.m_tlast, bus.m_tdata}));
      if (bus.pkt_ok) obs_ev.push_back(4);
      if (bus.pkt_err) obs_ev.push_back(int'(bus.err_code));
      if (bus.pkt_ok && bus.pkt_err) both_viol++;
      if (bus.m_tvalid && bus.s_tready) rdy_viol++;
      if (prev_stall && (!bus.m_tvalid || {bus.m_tlast, bus.m_tdata} != prev_dl)) stab_viol++;
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_dl    = {bus.m_tlast, bus.m_tdata};
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic p, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_tdata = d; bus.s_perr = p; bus.s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_tready) break;
      n++;
      if (n > 500) break;
    end
    if (n > 500) chk("send_wait_timeout", 1, 0);
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0; bus.s_perr = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i], 1'b0, 0);
  endtask

  // Reference: walks the byte stream by the framing rules, emitting events (4=ok, else err code) and payload bytes.
  task automatic model();
    int i = 0;
    int n = sd.size();
    int L;
    logic [7:0] sum;
    logic [7:0] pl[$];
    bit found, abort;
    exp_d.delete(); exp_ev.delete();
    while (i < n) begin
      if (sp[i] || sd[i] != 8'h55) begin i++; continue; end
      i++; found = 0;
      while (i < n) begin
        if (sp[i]) begin i++; break; end
        if (sd[i] == 8'hAA) begin i++; found = 1; break; end
        if (sd[i] == 8'h55) begin i++; continue; end
        i++; break;
      end
      if (!found) continue;
      if (i >= n) return;
      if (sp[i]) begin exp_ev.push_back(3); i++; continue; end
      L = int'(sd[i]); i++;
      if (L == 0 || L > 16) begin exp_ev.push_back(1); continue; end
      sum = 8'(L); pl.delete(); abort = 0;
      for (int k = 0; k < L; k++) begin
        if (i >= n) return;
        if (sp[i]) begin exp_ev.push_back(3); i++; abort = 1; break; end
        pl.push_back(sd[i]); sum = sum + sd[i]; i++;
      end
      if (abort) continue;
      if (i >= n) return;
      if (sp[i]) exp_ev.push_back(3);
      else if (sd[i] == sum) begin
        exp_ev.push_back(4);
        for (int k = 0; k < L; k++) exp_d.push_back(((k == L - 1) ? 256 : 0) + int'(pl[k]));
      end else exp_ev.push_back(2);
      i++;
    end
  endtask

  task automatic add_frame(input int kind);
    int L = $urandom_range(1, 16);
    logic [7:0] s;
    logic [7:0] fb[$];
    bit fp[$];
    int ppos;
    if (kind == 4) begin
      repeat ($urandom_range(1, 4)) begin
        sd.push_back(8'($urandom)); sp.push_back($urandom_range(0, 3) == 0);
      end
      return;
    end
    if (kind == 5) begin sd.push_back(8'h55); sp.push_back(0); end
    if (kind == 6) begin sd.push_back(8'h55); sp.push_back(1); end
    fb.push_back(8'h55); fb.push_back(8'hAA);
    if (kind == 2) begin
      fb.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
    end else begin
      fb.push_back(8'(L)); s = 8'(L);
      for (int k = 0; k < L; k++) begin
        fb.push_back(8'($urandom)); s = s + fb[fb.size() - 1];
      end
      if (kind == 1) s = s ^ 8'($urandom_range(1, 255));
      fb.push_back(s);
    end
    foreach (fb[k]) fp.push_back(0);
    if (kind == 3) begin
      ppos = $urandom_range(2, fb.size() - 1);
      fp[ppos] = 1;
    end
    foreach (fb[k]) begin sd.push_back(fb[k]); sp.push_back(fp[k]); end
  endtask

  initial begin
    int w;
    bus.s_tdata = 8'h00; bus.s_tvalid = 1'b0; bus.s_perr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", int'(bus.s_tready), 0);
    chk("rst_m_tvalid", int'(bus.m_tvalid), 0);
    chk("rst_m_tlast", int'(bus.m_tlast), 0);
    chk("rst_m_tdata", int'(bus.m_tdata), 0);
    chk("rst_pkt_ok", int'(bus.pkt_ok), 0);
    chk("rst_pkt_err", int'(bus.pkt_err), 0);
    chk("rst_err_code", int'(bus.err_code), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("idle_s_tready", int'(bus.s_tready), 1);

    // good packet with 5-cycle backpressure on the first output byte
    rdy_dir = 1'b0;
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    chk("s1_pkt_ok", int'(bus.pkt_ok), 1);
    chk("s1_pkt_err", int'(bus.pkt_err), 0);
    chk("s1_first_vld", int'(bus.m_tvalid), 1);
    chk("s1_first_data", int'(bus.m_tdata), 'h11);
    chk("s1_first_last", int'(bus.m_tlast), 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("s5_hold_data", int'(bus.m_tdata), 'h11);
      chk("s5_hold_vld", int'(bus.m_tvalid), 1);
      chk("s5_hold_s_tready", int'(bus.s_tready), 0);
      chk("s5_pkt_ok_pulse", int'(bus.pkt_ok), 0);
    end
    rdy_dir = 1'b1;
    @(posedge clk); #1;
    chk("s1_data2", int'(bus.m_tdata), 'h22);
    chk("s1_last2", int'(bus.m_tlast), 0);
    @(posedge clk); #1;
    chk("s1_data3", int'(bus.m_tdata), 'h33);
    chk("s1_last3", int'(bus.m_tlast), 1);
    @(posedge clk); #1;
    chk("s1_vld_drop", int'(bus.m_tvalid), 0);
    chk("s1_ready_back", int'(bus.s_tready), 1);

    // bad checksum
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68});
    chk("s2_pkt_err", int'(bus.pkt_err), 1);
    chk("s2_code", int'(bus.err_code), 2);
    chk("s2_no_ok", int'(bus.pkt_ok), 0);
    chk("s2_no_vld", int'(bus.m_tvalid), 0);
    @(posedge clk); #1;
    chk("s2_err_pulse_end", int'(bus.pkt_err), 0);
    chk("s2_code_hold", int'(bus.err_code), 2);

    // bad lengths at both edges
    send_seq('{8'h55, 8'hAA, 8'h00});
    chk("s3_len0_err", int'(bus.pkt_err), 1);
    chk("s3_len0_code", int'(bus.err_code), 1);
    send_seq('{8'h55, 8'hAA, 8'h11});
    chk("s3_len17_err", int'(bus.pkt_err), 1);
    chk("s3_len17_code", int'(bus.err_code), 1);

    // parity error in payload
    send_seq('{8'h55, 8'hAA, 8'h02});
    send(8'h10, 1'b1, 0);
    chk("s6_perr_err", int'(bus.pkt_err), 1);
    chk("s6_perr_code", int'(bus.err_code), 3);

    // reset mid-payload, then a resync frame must parse cleanly
    send_seq('{8'h55, 8'hAA, 8'h02, 8'h10});
    rst_n = 1'b1;
    #1;
    chk("s6_rst_s_tready", int'(bus.s_tready), 0);
    @(posedge clk); #1;
    chk("s6_rst_no_err", int'(bus.pkt_err), 0);
    chk("s6_rst_no_ok", int'(bus.pkt_ok), 0);
    rst_n = 1'b0;
    send_seq('{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F});
    chk("s4_pkt_ok", int'(bus.pkt_ok), 1);
    chk("s4_data", int'(bus.m_tdata), 'h7E);
    chk("s4_last", int'(bus.m_tlast), 1);
    @(posedge clk); #1;
    chk("s4_vld_drop", int'(bus.m_tvalid), 0);
    chk("s4_ok_pulse_end", int'(bus.pkt_ok), 0);

    // randomized streams with random gaps and random sink stalls
    rnd_rdy = 1'b1;
    for (int it = 0; it < 4; it++) begin
      rst_n = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      sd.delete(); sp.delete(); obs_d.delete(); obs_ev.delete();
      both_viol = 0; stab_viol = 0; rdy_viol = 0;
      repeat (12) add_frame($urandom_range(0, 6));
      add_frame(0);
      model();
      mon_en = 1'b1;
      foreach (sd[i]) send(sd[i], sp[i], $urandom_range(0, 2));
      w = 0;
      while ((obs_ev.size() != exp_ev.size() || obs_d.size() != exp_d.size() || bus.m_tvalid) && w < 1000) begin
        @(posedge clk); #1; w++;
      end
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;
      chk("rnd_ev_count", obs_ev.size(), exp_ev.size());
      chk("rnd_data_count", obs_d.size(), exp_d.size());
      foreach (exp_ev[i]) if (i < obs_ev.size()) chk("rnd_event", obs_ev[i], exp_ev[i]);
      foreach (exp_d[i]) if (i < obs_d.size()) chk("rnd_data_last", obs_d[i], exp_d[i]);
      chk("rnd_ok_err_overlap", both_viol, 0);
      chk("rnd_stall_stable", stab_viol, 0);
      chk("rnd_no_accept_in_out", rdy_viol, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_pkt_parser.md
Name: uart_pkt_parser

Overview:
Downstream consumer of the UART receive byte stream. It attaches to the UART data_out/data_out_valid/data_out_ready/check_flag outputs. It hunts for a two-byte header, reads a length byte, buffers the payload, and verifies an 8-bit additive checksum. Only verified payloads are released on a valid/ready byte stream with tlast; bad frames are dropped and reported with an error pulse.

Parameters:
HDR0, 8'h55, first header byte
HDR1, 8'hAA, second header byte
MAX_LEN, 16, maximum payload length in bytes (1..255); also the internal buffer depth
TIMEOUT_CYCLES, 50000, inter-byte timeout in clk cycles (used only with PKT_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high
s_tdata  input  8  received byte from UART
s_tvalid  input  1  received byte valid
s_tready  output  1  parser accepts byte
s_perr  input  1  parity error flag for the current byte, qualified by s_tvalid
m_tdata  output  8  verified payload byte
m_tvalid  output  1  payload byte valid
m_tready  input  1  downstream ready
m_tlast  output  1  last payload byte of packet
pkt_ok  output  1  one-cycle pulse, packet verified
pkt_err  output  1  one-cycle pulse, packet dropped
err_code  output  2  error cause, valid with pkt_err: 00 timeout, 01 bad length, 10 checksum, 11 parity

Behaviour:
- Reset (rst_n=1): state=HUNT0. m_tvalid, m_tlast, pkt_ok and pkt_err are 0. m_tdata=0, err_code=0, s_tready=0. Length, index and checksum registers are 0.
- Input accept = s_tvalid & s_tready.
- s_tready = 1 in every state except OUT, and is forced 0 while in reset.
- States and transitions, all evaluated on an accepted byte b:
  - HUNT0: b==HDR0 -> HUNT1; otherwise stay. Bytes with s_perr are discarded, no error.
  - HUNT1: b==HDR1 -> LEN. b==HDR0 -> stay in HUNT1 (resync). Otherwise -> HUNT0. Bytes with s_perr -> HUNT0, no error.
  - LEN: if b==0 or b>MAX_LEN -> HUNT0 with pkt_err and err_code=01. Otherwise latch len=b, sum=b, idx=0, then -> PAYLOAD.
  - PAYLOAD: buf[idx]=b; sum=sum+b (mod 256); idx++. When idx reaches len -> CSUM.
  - CSUM: if b==sum -> OUT, with pkt_ok pulsed in the cycle following acceptance and idx cleared. Otherwise -> HUNT0 with pkt_err and err_code=10.
  - OUT: m_tvalid=1, m_tdata=buf[idx], m_tlast=(idx==len-1). On m_tvalid&m_tready, idx++. When the last byte transfers -> HUNT0, and m_tvalid drops in the next cycle.
- Parity: in LEN, PAYLOAD or CSUM, any accepted byte with s_perr=1 aborts the frame -> HUNT0 with pkt_err and err_code=11. The byte's value is ignored.
- Latency: the first m_tvalid is asserted in the cycle after the checksum byte is accepted, the same cycle as pkt_ok.
- Backpressure: while m_tready=0 in OUT, m_tdata and m_tlast are held stable and m_tvalid stays 1. No input is accepted during OUT.
- pkt_ok and pkt_err are registered pulses, exactly 1 cycle, and never asserted together. err_code holds its value until the next pkt_err.
- Buffer writes use idx only, with no wrap-around. idx is bounded by len, which is at most MAX_LEN.
- Reset asserted mid-frame or mid-OUT returns to HUNT0 immediately (asynchronously). Partial data is discarded, with no pulse on either pkt_ok or pkt_err.

Optional Feature:
Macro PKT_TIMEOUT_EN.
- Defined: a counter runs in HUNT1, LEN, PAYLOAD and CSUM. It is cleared on every accepted byte and on every state entry. When it reaches TIMEOUT_CYCLES without an accepted byte, the state goes to HUNT0. From LEN, PAYLOAD or CSUM this also pulses pkt_err with err_code=00. From HUNT1 it returns silently.
- Not defined: no counter and no timeout. The parser waits indefinitely, TIMEOUT_CYCLES is ignored, and err_code=00 is never reported.

Test Plan:
1. Send 55 AA 03 11 22 33 69 -> pkt_ok once; then m_tdata 11,22,33 with m_tlast only on 33; no pkt_err.
2. Send 55 AA 03 11 22 33 68 -> pkt_err with err_code=10; m_tvalid never asserts; the next good packet from scenario 1 passes.
3. Send 55 AA 00, then 55 AA 11 (MAX_LEN=16) -> two pkt_err pulses, both err_code=01; parser returns to HUNT0 each time.
4. Send 55 55 AA 01 7E 7F -> resync on the second 55; output 7E with m_tlast=1 and pkt_ok.
5. Scenario 1 with m_tready=0 for 5 cycles after the first output byte -> 11 held stable, s_tready=0 throughout OUT, all three bytes delivered in order.
6. Send 55 AA 02 10 with s_perr=1 on 10 -> pkt_err with err_code=11. Separately, with PKT_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 55 AA 02 10, then idle 100 cycles -> pkt_err with err_code=00. Separately, reset mid-PAYLOAD -> no pulse, parser back in HUNT0.
